// File: rtl/status_event_monitor.sv
// Per-channel event monitor: synchronises event inputs, counts rising edges with saturation,
// keeps sticky event/overflow flags and exposes a software-triggered counter snapshot.
module status_event_monitor #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_CH-1:0]                event_i,
  input  logic [NUM_CH-1:0]                clear_i,
  input  logic                             snap_req_i,
  output logic [DATA_WIDTH*(NUM_CH+2)-1:0] status_bus_o,
  output logic [DATA_WIDTH-1:0]            snap_cnt_o
);

  logic [NUM_CH-1:0]     r_sync [SYNC_STAGES];
  logic [NUM_CH-1:0]     r_prev;
  logic [DATA_WIDTH-1:0] r_cnt  [NUM_CH];
  logic [DATA_WIDTH-1:0] r_snap [NUM_CH];
  logic [NUM_CH-1:0]     r_evt_flag;
  logic [NUM_CH-1:0]     r_ovf_flag;
  logic                  r_snap_prev;
  logic [DATA_WIDTH-1:0] r_snap_cnt;

  logic [NUM_CH-1:0]     w_sync;
  logic [NUM_CH-1:0]     w_edge;
  logic                  w_snap_edge;
  logic [DATA_WIDTH-1:0] w_cnt_d [NUM_CH];
  logic [NUM_CH-1:0]     w_evt_d;
  logic [NUM_CH-1:0]     w_ovf_d;
  logic [DATA_WIDTH-1:0] w_flags;
  logic [DATA_WIDTH-1:0] w_live;

  assign w_sync      = r_sync[SYNC_STAGES-1];
  assign w_edge      = w_sync & ~r_prev;
  assign w_snap_edge = snap_req_i & ~r_snap_prev;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
        r_sync[s] <= '0;
      end
      r_prev <= '0;
    end else begin
      r_sync[0] <= event_i;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
        r_sync[s] <= r_sync[s-1];
      end
      r_prev <= w_sync;
    end
  end

  // Clear wins over edges; a saturated counter holds and raises the overflow flag instead.
  always_comb begin
    w_evt_d = r_evt_flag;
    w_ovf_d = r_ovf_flag;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_cnt_d[c] = r_cnt[c];
      if (clear_i[c]) begin
        w_cnt_d[c] = '0;
        w_evt_d[c] = 1'b0;
        w_ovf_d[c] = 1'b0;
      end else if (w_edge[c]) begin
        w_evt_d[c] = 1'b1;
        if (r_cnt[c] != '1) begin
          w_cnt_d[c] = r_cnt[c] + DATA_WIDTH'(1);
        end else begin
          w_ovf_d[c] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
      end
      r_evt_flag <= '0;
      r_ovf_flag <= '0;
    end else begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= w_cnt_d[c];
      end
      r_evt_flag <= w_evt_d;
      r_ovf_flag <= w_ovf_d;
    end
  end

  // Snapshot takes the pre-update counter values, so same-cycle clears/edges are not seen.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        r_snap[c] <= '0;
      end
      r_snap_prev <= 1'b0;
      r_snap_cnt  <= '0;
    end else begin
      r_snap_prev <= snap_req_i;
      if (w_snap_edge) begin
        for (int unsigned c = 0; c < NUM_CH; c++) begin
          r_snap[c] <= r_cnt[c];
        end
        r_snap_cnt <= r_snap_cnt + DATA_WIDTH'(1);
      end
    end
  end

  always_comb begin
    w_flags = '0;
    w_live  = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      w_flags[c]     = r_evt_flag[c];
      w_flags[4 + c] = r_ovf_flag[c];
      w_live[c]      = w_sync[c];
    end
  end

  // Every byte of the bus is a plain register image; no input reaches it combinationally.
  always_comb begin
    status_bus_o = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      status_bus_o[c*DATA_WIDTH +: DATA_WIDTH] = r_snap[c];
    end
    status_bus_o[NUM_CH*DATA_WIDTH +: DATA_WIDTH]     = w_flags;
    status_bus_o[(NUM_CH+1)*DATA_WIDTH +: DATA_WIDTH] = w_live;
  end

  assign snap_cnt_o = r_snap_cnt;

endmodule

// File: tb/tb_status_event_monitor.sv
// Directed bench for status_event_monitor: a behavioural model pushes expected
// {snap_cnt, status_bus} words to a scoreboard that is popped when the DUT responds.
module tb_status_event_monitor;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic [3:0]  event_i = '0;
  logic [3:0]  clear_i = '0;
  logic        snap_req_i = 1'b0;
  logic [47:0] status_bus_o;
  logic [7:0]  snap_cnt_o;

  status_event_monitor dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .event_i      (event_i),
    .clear_i      (clear_i),
    .snap_req_i   (snap_req_i),
    .status_bus_o (status_bus_o),
    .snap_cnt_o   (snap_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [55:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  logic [7:0] m_cnt  [4];
  logic [7:0] m_snap [4];
  logic [3:0] m_evt;
  logic [3:0] m_ovf;
  logic [7:0] m_snapcnt;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [55:0] exp_word(logic [7:0] live);
    logic [55:0] w;
    w = '0;
    for (int c = 0; c < 4; c++) w[8*c +: 8] = m_snap[c];
    w[39:32] = {m_ovf, m_evt};
    w[47:40] = live;
    w[55:48] = m_snapcnt;
    return w;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_cnt[c]  = '0;
      m_snap[c] = '0;
    end
    m_evt     = '0;
    m_ovf     = '0;
    m_snapcnt = '0;
  endtask

  task automatic model_edge(int c);
    if (!clear_i[c]) begin
      m_evt[c] = 1'b1;
      if (m_cnt[c] == 8'hFF) m_ovf[c] = 1'b1;
      else m_cnt[c] = m_cnt[c] + 8'd1;
    end
  endtask

  task automatic model_clear(int c);
    m_cnt[c] = '0;
    m_evt[c] = 1'b0;
    m_ovf[c] = 1'b0;
  endtask

  task automatic model_snap();
    for (int c = 0; c < 4; c++) m_snap[c] = m_cnt[c];
    m_snapcnt = m_snapcnt + 8'd1;
  endtask

  task automatic sb_push(string tag, logic [55:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_check();
    sb_t e;
    logic [55:0] obs;
    obs = {snap_cnt_o, status_bus_o};
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty observed=%h expected=<entry>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) else begin
        n_errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic do_reset();
    clear_i    = '0;
    snap_req_i = 1'b0;
    rst_i      = 1'b1;
    repeat (2) tick();
    model_reset();
    sb_push("reset_state", 56'h0);
    sb_check();
    rst_i = 1'b0;
  endtask

  task automatic pulse(int c, int hi, int lo);
    event_i[c] = 1'b1;
    repeat (hi) tick();
    event_i[c] = 1'b0;
    repeat (lo) tick();
    model_edge(c);
  endtask

  task automatic wait_snapcnt();
    for (int i = 0; i < 8 && snap_cnt_o !== m_snapcnt; i++) tick();
  endtask

  task automatic do_snapshot(string tag);
    repeat (4) tick();
    model_snap();
    sb_push(tag, exp_word({4'b0, event_i}));
    snap_req_i = 1'b1;
    wait_snapcnt();
    sb_check();
    snap_req_i = 1'b0;
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Inputs already high at reset release count once, as prev starts at 0.
    event_i = 4'hF;
    do_reset();
    repeat (5) tick();
    for (int c = 0; c < 4; c++) model_edge(c);
    sb_push("held_high_pre_snap", exp_word(8'h0F));
    sb_check();
    do_snapshot("held_high_snap");
    event_i = '0;

    // 10 clean pulses on channel 1.
    do_reset();
    for (int i = 0; i < 10; i++) pulse(1, 2, 2);
    do_snapshot("ch1_ten_pulses");

    // Saturation, overflow flag, then clears.
    do_reset();
    for (int i = 0; i < 260; i++) pulse(0, 2, 2);
    do_snapshot("ch0_saturate");
    clear_i[0] = 1'b1;
    tick();
    clear_i[0] = 1'b0;
    model_clear(0);
    do_snapshot("ch0_after_clear");
    for (int i = 0; i < 3; i++) pulse(0, 2, 2);
    repeat (4) tick();
    clear_i[0] = 1'b1;
    snap_req_i = 1'b1;
    model_snap();
    model_clear(0);
    sb_push("clear_with_snap", exp_word(8'h00));
    tick();
    clear_i[0] = 1'b0;
    snap_req_i = 1'b0;
    sb_check();
    tick();
    do_snapshot("after_clear_with_snap");

    // Channel 2 edge lands in the same cycle as snap_edge.
    do_reset();
    for (int i = 0; i < 5; i++) pulse(2, 2, 2);
    repeat (4) tick();
    event_i[2] = 1'b1;
    repeat (2) tick();
    snap_req_i = 1'b1;
    model_snap();
    model_edge(2);
    sb_push("edge_with_snap", exp_word(8'h04));
    tick();
    sb_check();
    snap_req_i = 1'b0;
    event_i[2] = 1'b0;
    tick();
    do_snapshot("edge_with_snap_next");

    // Held snap request counts once.
    repeat (4) tick();
    model_snap();
    sb_push("held_snap_first", exp_word(8'h00));
    snap_req_i = 1'b1;
    wait_snapcnt();
    sb_check();
    repeat (19) tick();
    sb_push("held_snap_no_repeat", exp_word(8'h00));
    sb_check();
    snap_req_i = 1'b0;
    tick();

    // Edges ignored while clear held.
    clear_i[3] = 1'b1;
    for (int i = 0; i < 5; i++) pulse(3, 2, 2);
    repeat (4) tick();
    clear_i[3] = 1'b0;
    do_snapshot("ch3_clear_held");

    // Fastest legal pulses, then live-level latency.
    do_reset();
    for (int i = 0; i < 40; i++) pulse(0, 1, 1);
    do_snapshot("ch0_fast_pulses");
    event_i[2] = 1'b1;
    tick();
    sb_push("live_after_1", exp_word(8'h00));
    sb_check();
    tick();
    sb_push("live_after_2", exp_word(8'h04));
    sb_check();
    event_i[2] = 1'b0;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/status_event_monitor.md
Name: status_event_monitor

Overview:
Per-channel event monitor that feeds the register map's status bus.
- Synchronises asynchronous pad/event inputs into the system clock domain and detects rising edges.
- Keeps saturating event counters, sticky event flags and sticky overflow flags per channel.
- Presents a software-triggered snapshot of the counters as read-only status bytes.
- Clear and snapshot controls come from config-bus bits, so SPI writes arm and clear the monitor.

Parameters:
NUM_CH, 4, number of monitored channels (1..4)
DATA_WIDTH, 8, counter width and status byte width
SYNC_STAGES, 2, synchroniser flops per input (>=2)

Ports:
clk_i  input  1  system clock
rst_i  input  1  reset; one clock; reset is synchronous and active-high
event_i  input  NUM_CH  asynchronous event inputs, one per channel
clear_i  input  NUM_CH  per-channel clear, level, from config bus
snap_req_i  input  1  snapshot request, level, from config bus; acts on rising edge
status_bus_o  output  DATA_WIDTH*(NUM_CH+2)  byte k (k<NUM_CH) = snapshot of counter k; byte NUM_CH = flags; byte NUM_CH+1 = live levels
snap_cnt_o  output  DATA_WIDTH  number of snapshots taken, wraps 0xFF->0x00

Behaviour:
- Reset (rst_i high at a clk_i edge): all synchroniser flops, edge-history flops, counters, snapshots, flags, snap_req history and snap_cnt_o go to 0. status_bus_o is all-zero the cycle after reset.
- Synchroniser: event_i[c] passes through SYNC_STAGES flops to give sync[c]. prev[c] registers sync[c].
- Edge detection: edge[c] = sync[c] & ~prev[c].
  - Input stable high before edge E0 gives a counter increment visible after edge E0+SYNC_STAGES (edge 2 for default).
  - Each pulse needs >=1 full clock high and >=1 full clock low to count. Shorter pulses may be lost; no double-count is ever allowed.
- Counter c, priority per cycle:
  1. clear_i[c]=1: counter, event flag and overflow flag for channel c go to 0. Edges are ignored for the whole time clear_i[c] is high.
  2. Else if edge[c]=1 and counter < 2^DATA_WIDTH-1: counter +1, event flag set.
  3. Else if edge[c]=1 and counter = all-ones: counter holds at all-ones, event flag set, overflow flag set.
  4. Else: hold.
- Flags byte: bit c = sticky event flag c (bits 0..3); bit 4+c = sticky overflow flag c (bits 4..7). Bits for c>=NUM_CH read 0.
- Live-levels byte: bit c = sync[c]; other bits 0.
- Snapshot:
  - snap_prev registers snap_req_i. snap_edge = snap_req_i & ~snap_prev.
  - On snap_edge, snapshot[c] <= counter[c] (registered value before that cycle's update) for all channels, and snap_cnt_o increments.
  - A held-high snap_req_i gives exactly one snapshot; software must write 0 then 1 to re-arm.
  - Snapshot bytes change only on snap_edge or reset, never on clear_i.
- Simultaneous events:
  - snap_edge and an edge in the same cycle: snapshot captures the pre-increment value; counter increments.
  - clear_i and snap_edge in the same cycle: snapshot captures the pre-clear value; counter clears.
- Reset mid-operation: synchronous reset overrides everything in that cycle. An event_i already high at reset release counts as an edge once it propagates through the synchroniser, because prev starts at 0.
- All outputs are registered; no combinational path from any input to status_bus_o.

Test Plan:
- Reset with event_i=4'hF held -> after release, counters read 0 until a snapshot; a snapshot taken 5 cycles later reads 0x01 on all channels and flags byte=0x0F.
- 10 clean pulses (2 clk high, 2 low) on channel 1, then snap_req_i 0->1 -> byte1=0x0A, other counter bytes 0x00, flags=0x02, snap_cnt_o=0x01.
- 260 pulses on channel 0, snapshot -> byte0=0xFF, flags=0x11. Pulse clear_i[0] for 1 cycle, then snapshot -> byte0=0x00, flags=0x00, snap_cnt_o=0x02.
- Event edge on channel 2 in the same cycle as snap_edge with counter=0x05 -> snapshot byte2=0x05; next snapshot byte2=0x06.
- Hold snap_req_i high 20 cycles -> snap_cnt_o increments exactly once. Hold clear_i[3] high while pulsing event_i[3] 5 times -> counter3 stays 0 and flag bit3=0.
- Pulses of 1 clk high / 1 clk low on channel 0 (40 pulses), then snapshot -> byte0=0x28. Drive event_i[2] high -> live byte bit2=1 after 2 cycles.
